// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle controller (master) and the
// datapath it sequences (slave): instruction fields in, enables/selects out.
interface mc_ctrl_if;
   logic [5:0]  Op;
   logic [5:0]  Funct;
   logic        Zero;
   logic        PCWr;
   logic        IRWr;
   logic        RFWr;
   logic        DMWr;
   logic        BSel;
   logic [1:0]  EXTOp;
   logic [1:0]  ALUOp;
   logic [1:0]  NPCOp;
   logic        RegDst;
   logic        WDSel;
   logic [3:0]  state;
   logic        halt;
   logic [31:0] instr_cnt;

   modport master (
      input  Op, Funct, Zero,
      output PCWr, IRWr, RFWr, DMWr, BSel, EXTOp, ALUOp, NPCOp,
             RegDst, WDSel, state, halt, instr_cnt
   );

   modport slave (
      output Op, Funct, Zero,
      input  PCWr, IRWr, RFWr, DMWr, BSel, EXTOp, ALUOp, NPCOp,
             RegDst, WDSel, state, halt, instr_cnt
   );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: one instruction at a time, 2..5 cycles each.
// Illegal encodings park the FSM in TRAP with a sticky halt until reset.
module mc_ctrl (
   input  logic      clk,
   input  logic      rst,
   mc_ctrl_if.master bus
);

   typedef enum logic [3:0] {
      S_FETCH = 4'd0,
      S_DCD   = 4'd1,
      S_EXE   = 4'd2,
      S_ALUWB = 4'd3,
      S_MA    = 4'd4,
      S_MR    = 4'd5,
      S_MWB   = 4'd6,
      S_MW    = 4'd7,
      S_BR    = 4'd8,
      S_TRAP  = 4'd15
   } state_e;

   state_e      state_q, state_d;
   logic        halt_q, halt_d;
   logic [31:0] cnt_q, cnt_d;

   logic        is_r, is_addu, is_subu, is_ori, is_lui;
   logic        is_lw, is_sw, is_beq, is_j, is_alu, is_mem;

   logic        pcwr_c, irwr_c, rfwr_c, dmwr_c;
   logic        bsel_c, regdst_c, wdsel_c, retire;
   logic [1:0]  extop_c, aluop_c, npcop_c;

   logic        alu_bsel;
   logic [1:0]  alu_ext, alu_op;

   assign is_r    = (bus.Op == 6'b000000);
   assign is_addu = is_r && (bus.Funct == 6'b100001);
   assign is_subu = is_r && (bus.Funct == 6'b100011);
   assign is_ori  = (bus.Op == 6'b001101);
   assign is_lui  = (bus.Op == 6'b001111);
   assign is_lw   = (bus.Op == 6'b100011);
   assign is_sw   = (bus.Op == 6'b101011);
   assign is_beq  = (bus.Op == 6'b000100);
   assign is_j    = (bus.Op == 6'b000010);
   assign is_alu  = is_addu | is_subu | is_ori | is_lui;
   assign is_mem  = is_lw | is_sw;

   // EXE and ALUWB share these so the ALU result stays stable into write-back
   always_comb begin
      alu_bsel = 1'b0;
      alu_ext  = 2'b00;
      alu_op   = 2'b00;
      if (is_subu) begin
         alu_op   = 2'b01;
      end else if (is_ori) begin
         alu_bsel = 1'b1;
         alu_op   = 2'b10;
      end else if (is_lui) begin
         alu_bsel = 1'b1;
         alu_ext  = 2'b10;
         alu_op   = 2'b11;
      end
   end

   always_comb begin
      state_d  = state_q;
      pcwr_c   = 1'b0;
      irwr_c   = 1'b0;
      rfwr_c   = 1'b0;
      dmwr_c   = 1'b0;
      bsel_c   = 1'b0;
      extop_c  = 2'b00;
      aluop_c  = 2'b00;
      npcop_c  = 2'b00;
      regdst_c = 1'b0;
      wdsel_c  = 1'b0;
      retire   = 1'b0;
      case (state_q)
         S_FETCH: begin
            irwr_c  = 1'b1;
            pcwr_c  = 1'b1;
            state_d = S_DCD;
         end
         S_DCD: begin
            if (is_alu) begin
               state_d = S_EXE;
            end else if (is_mem) begin
               state_d = S_MA;
            end else if (is_beq) begin
               state_d = S_BR;
            end else if (is_j) begin
               pcwr_c  = 1'b1;
               npcop_c = 2'b10;
               retire  = 1'b1;
               state_d = S_FETCH;
            end else begin
               state_d = S_TRAP;
            end
         end
         S_EXE: begin
            bsel_c  = alu_bsel;
            extop_c = alu_ext;
            aluop_c = alu_op;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            bsel_c   = alu_bsel;
            extop_c  = alu_ext;
            aluop_c  = alu_op;
            rfwr_c   = 1'b1;
            regdst_c = is_r;
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         S_MA: begin
            bsel_c  = 1'b1;
            extop_c = 2'b01;
            state_d = is_lw ? S_MR : S_MW;
         end
         S_MR: begin
            bsel_c  = 1'b1;
            extop_c = 2'b01;
            state_d = S_MWB;
         end
         S_MWB: begin
            bsel_c  = 1'b1;
            extop_c = 2'b01;
            rfwr_c  = 1'b1;
            wdsel_c = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_MW: begin
            bsel_c  = 1'b1;
            extop_c = 2'b01;
            dmwr_c  = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_BR: begin
            aluop_c = 2'b01;
            extop_c = 2'b01;
            if (bus.Zero) begin
               pcwr_c  = 1'b1;
               npcop_c = 2'b01;
            end
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_TRAP: begin
            state_d = S_TRAP;
         end
         default: begin
            state_d = S_TRAP;
         end
      endcase
   end

   assign halt_d = halt_q | (state_d == S_TRAP);
   assign cnt_d  = cnt_q + {31'd0, retire};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_FETCH;
         halt_q  <= 1'b0;
         cnt_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         halt_q  <= halt_d;
         cnt_q   <= cnt_d;
      end
   end

   // Enables are gated by reset itself so an abort cannot leak a write pulse
   assign bus.PCWr      = pcwr_c & rst;
   assign bus.IRWr      = irwr_c & rst;
   assign bus.RFWr      = rfwr_c & rst;
   assign bus.DMWr      = dmwr_c & rst;
   assign bus.BSel      = bsel_c;
   assign bus.EXTOp     = extop_c;
   assign bus.ALUOp     = aluop_c;
   assign bus.NPCOp     = npcop_c;
   assign bus.RegDst    = regdst_c;
   assign bus.WDSel     = wdsel_c;
   assign bus.state     = state_q;
   assign bus.halt      = halt_q;
   assign bus.instr_cnt = cnt_q;

   a_one_mem_wr: assert property (@(posedge clk) disable iff (!rst)
      !(bus.RFWr && bus.DMWr));
   a_irwr_fetch: assert property (@(posedge clk) disable iff (!rst)
      bus.IRWr |-> (state_q == S_FETCH));
   a_pcwr_legal: assert property (@(posedge clk) disable iff (!rst)
      bus.PCWr |-> (state_q == S_FETCH || state_q == S_DCD || state_q == S_BR));

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboarded bench for mc_ctrl: per-cycle expectations from an instruction-level model.
module tb_mc_ctrl;

   typedef struct packed {
      logic [3:0]  st;
      logic        pcwr, irwr, rfwr, dmwr, bsel;
      logic [1:0]  extop, aluop, npcop;
      logic        regdst, wdsel, halt;
      logic [31:0] cnt;
   } rec_t;

   localparam int C_ADDU = 0, C_SUBU = 1, C_ORI = 2, C_LUI = 3, C_LW = 4,
                  C_SW = 5, C_BEQ = 6, C_J = 7, C_ILL = 8;

   logic clk = 1'b0;
   logic rst;
   mc_ctrl_if bus();

   mc_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   rec_t        exp_q[$];
   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   logic [31:0] model_cnt = 32'd0;

   always @(negedge clk) begin
      rec_t act, e;
      act.st     = bus.state;
      act.pcwr   = bus.PCWr;
      act.irwr   = bus.IRWr;
      act.rfwr   = bus.RFWr;
      act.dmwr   = bus.DMWr;
      act.bsel   = bus.BSel;
      act.extop  = bus.EXTOp;
      act.aluop  = bus.ALUOp;
      act.npcop  = bus.NPCOp;
      act.regdst = bus.RegDst;
      act.wdsel  = bus.WDSel;
      act.halt   = bus.halt;
      act.cnt    = bus.instr_cnt;
      cyc++;
      checks++;
      if (act.rfwr && act.dmwr) begin
         failures++;
         $display("FAIL rf_dm_excl cyc=%0d got both RFWr and DMWr, need at most one", cyc);
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (act !== e) begin
            failures++;
            $display("FAIL cycle_%0d got st=%0d pc=%b ir=%b rf=%b dm=%b b=%b ext=%b alu=%b npc=%b rd=%b wd=%b h=%b cnt=%0d need st=%0d pc=%b ir=%b rf=%b dm=%b b=%b ext=%b alu=%b npc=%b rd=%b wd=%b h=%b cnt=%0d",
                     cyc, act.st, act.pcwr, act.irwr, act.rfwr, act.dmwr, act.bsel, act.extop,
                     act.aluop, act.npcop, act.regdst, act.wdsel, act.halt, act.cnt,
                     e.st, e.pcwr, e.irwr, e.rfwr, e.dmwr, e.bsel, e.extop,
                     e.aluop, e.npcop, e.regdst, e.wdsel, e.halt, e.cnt);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'b000000: classify = (fn == 6'b100001) ? C_ADDU :
                               (fn == 6'b100011) ? C_SUBU : C_ILL;
         6'b001101: classify = C_ORI;
         6'b001111: classify = C_LUI;
         6'b100011: classify = C_LW;
         6'b101011: classify = C_SW;
         6'b000100: classify = C_BEQ;
         6'b000010: classify = C_J;
         default:   classify = C_ILL;
      endcase
   endfunction

   function automatic rec_t mk(input logic [3:0] st);
      rec_t r;
      r     = '0;
      r.st  = st;
      r.cnt = model_cnt;
      return r;
   endfunction

   task automatic step(input rec_t e, input logic zv);
      bus.Zero = zv;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst       = 1'b0;
      model_cnt = 32'd0;
      for (int i = 0; i < n; i++) step(mk(4'd0), 1'($urandom));
      rst = 1'b1;
   endtask

   // Expected cycle sequence for one instruction; cut>0 stops early (reset abort)
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input int cut);
      rec_t q[$];
      rec_t r;
      int   cls;
      logic bs;
      logic [1:0] ex, al;
      cls = classify(op, fn);
      bus.Op    = op;
      bus.Funct = fn;
      r = mk(4'd0); r.pcwr = 1'b1; r.irwr = 1'b1; q.push_back(r);
      r = mk(4'd1);
      if (cls == C_J) begin r.pcwr = 1'b1; r.npcop = 2'b10; end
      q.push_back(r);
      bs = 1'b0; ex = 2'b00; al = 2'b00;
      case (cls)
         C_SUBU: al = 2'b01;
         C_ORI:  begin bs = 1'b1; al = 2'b10; end
         C_LUI:  begin bs = 1'b1; ex = 2'b10; al = 2'b11; end
         C_LW, C_SW: begin bs = 1'b1; ex = 2'b01; end
         default: ;
      endcase
      case (cls)
         C_ADDU, C_SUBU, C_ORI, C_LUI: begin
            r = mk(4'd2); r.bsel = bs; r.extop = ex; r.aluop = al; q.push_back(r);
            r.st = 4'd3; r.rfwr = 1'b1; r.regdst = (cls == C_ADDU || cls == C_SUBU);
            q.push_back(r);
         end
         C_LW, C_SW: begin
            r = mk(4'd4); r.bsel = bs; r.extop = ex; q.push_back(r);
            if (cls == C_LW) begin
               r.st = 4'd5; q.push_back(r);
               r.st = 4'd6; r.rfwr = 1'b1; r.wdsel = 1'b1; q.push_back(r);
            end else begin
               r.st = 4'd7; r.dmwr = 1'b1; q.push_back(r);
            end
         end
         C_BEQ: begin
            r = mk(4'd8); r.aluop = 2'b01; r.extop = 2'b01;
            r.pcwr = z; r.npcop = z ? 2'b01 : 2'b00;
            q.push_back(r);
         end
         C_ILL: begin
            r = mk(4'd15); r.halt = 1'b1;
            for (int i = 0; i < 20; i++) q.push_back(r);
         end
         default: ;
      endcase
      for (int i = 0; i < q.size(); i++) begin
         if (cut > 0 && i >= cut) break;
         if (q[i].st == 4'd8) step(q[i], z);
         else begin
            if (cls == C_ILL && i >= 2) bus.Op = 6'($urandom);
            step(q[i], 1'($urandom));
         end
      end
      if (cut == 0 && cls != C_ILL) model_cnt = model_cnt + 32'd1;
   endtask

   logic [5:0] ops[8];
   logic [5:0] fns[8];

   initial begin
      ops = '{6'b000000, 6'b000000, 6'b001101, 6'b001111,
              6'b100011, 6'b101011, 6'b000100, 6'b000010};
      fns = '{6'b100001, 6'b100011, 6'b000000, 6'b000000,
              6'b000000, 6'b000000, 6'b000000, 6'b000000};
      rst       = 1'b0;
      bus.Op    = 6'b100011;
      bus.Funct = 6'b000000;
      bus.Zero  = 1'b0;
      @(posedge clk);
      #1;
      do_reset(3);

      run_instr(6'b000000, 6'b100001, 1'b0, 0);
      run_instr(6'b100011, 6'b010101, 1'b0, 0);
      run_instr(6'b101011, 6'b000000, 1'b0, 0);
      run_instr(6'b000100, 6'b000000, 1'b1, 0);
      run_instr(6'b000100, 6'b000000, 1'b0, 0);

      for (int n = 0; n < 60; n++) begin
         int k;
         logic [5:0] fn;
         k  = $urandom_range(0, 7);
         fn = (k < 2) ? fns[k] : 6'($urandom);
         run_instr(ops[k], fn, 1'($urandom), 0);
      end

      run_instr(6'b111111, 6'b000000, 1'b0, 0);
      do_reset(2);
      run_instr(6'b000000, 6'b100000, 1'b0, 0);
      do_reset(1);

      run_instr(6'b000010, 6'b000000, 1'b0, 0);
      run_instr(6'b100011, 6'b000000, 1'b0, 3);
      do_reset(2);
      run_instr(6'b001111, 6'b000000, 1'b0, 0);

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain got %0d pending expectations, need 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
